// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: default widths and entry type encodings.
// The all-ones tag is reserved as "no dependency", so depth is 2**width - 1.
package rob_pkg;
    localparam int ROB_SIZE_WIDTH_DEF = 3;
    localparam int REG_NUM_WIDTH_DEF  = 5;
    localparam int ROB_DEPTH_DEF      = 2**ROB_SIZE_WIDTH_DEF - 1;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2
    } rob_type_e;
endpackage

// File: rtl/rob_if.sv
// Dispatch, CDB, query, commit and flush signals of the reorder buffer; master is the core side.
interface rob_if
    import rob_pkg::*;
#(
    parameter int TW = ROB_SIZE_WIDTH_DEF,
    parameter int RW = REG_NUM_WIDTH_DEF
);
    logic          dec_valid;
    rob_type_e     dec_type;
    logic [RW-1:0] dec_rd;
    logic          dec_pred_taken;
    logic [31:0]   dec_alt_pc;
    logic [TW-1:0] alloc_tag;
    logic          full_out;

    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_value;
    logic          cdb_taken;

    logic [TW-1:0] qry1_tag;
    logic [TW-1:0] qry2_tag;
    logic          qry1_ready;
    logic          qry2_ready;
    logic [31:0]   qry1_value;
    logic [31:0]   qry2_value;

    logic          commit_valid;
    logic [RW-1:0] commit_rd;
    logic [31:0]   commit_value;
    logic [TW-1:0] commit_tag;
    logic          store_commit_valid;
    logic [TW-1:0] store_commit_tag;
    logic          need_flush_out;
    logic [31:0]   flush_pc;

    modport master (
        output dec_valid, dec_type, dec_rd, dec_pred_taken, dec_alt_pc,
        output cdb_valid, cdb_tag, cdb_value, cdb_taken, qry1_tag, qry2_tag,
        input  alloc_tag, full_out, qry1_ready, qry2_ready, qry1_value, qry2_value,
        input  commit_valid, commit_rd, commit_value, commit_tag,
        input  store_commit_valid, store_commit_tag, need_flush_out, flush_pc
    );

    modport slave (
        input  dec_valid, dec_type, dec_rd, dec_pred_taken, dec_alt_pc,
        input  cdb_valid, cdb_tag, cdb_value, cdb_taken, qry1_tag, qry2_tag,
        output alloc_tag, full_out, qry1_ready, qry2_ready, qry1_value, qry2_value,
        output commit_valid, commit_rd, commit_value, commit_tag,
        output store_commit_valid, store_commit_tag, need_flush_out, flush_pc
    );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order tag allocation, CDB writeback, one retirement per cycle (commit pulse
// one cycle after the head becomes ready), mispredict flush; dispatch is refused while full_out.
module rob
    import rob_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEF,
    parameter int REG_NUM_WIDTH  = REG_NUM_WIDTH_DEF
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    rob_if.slave  bus
);
    localparam int TW      = ROB_SIZE_WIDTH;
    localparam int RW      = REG_NUM_WIDTH;
    localparam int ENTRIES = 2**TW;
    localparam int DEPTH   = ENTRIES - 1;
    localparam logic [TW-1:0] NONE = '1;

    logic [ENTRIES-1:0] r_busy, r_ready, r_pred, r_act;
    rob_type_e          r_type  [ENTRIES];
    logic [RW-1:0]      r_rd    [ENTRIES];
    logic [31:0]        r_value [ENTRIES];
    logic [31:0]        r_alt   [ENTRIES];
    logic [TW-1:0]      r_head, r_tail, r_count;

    logic          r_commit_valid, r_store_commit_valid, r_need_flush;
    logic [RW-1:0] r_commit_rd;
    logic [31:0]   r_commit_value, r_flush_pc;
    logic [TW-1:0] r_commit_tag, r_store_commit_tag;

    logic w_full, w_disp, w_wb, w_commit, w_mispredict;

    function automatic logic [TW-1:0] inc(input logic [TW-1:0] p);
        return (p == TW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // CDB forwarding lets a consumer pick up a result in the same cycle it is broadcast.
    function automatic logic [32:0] lookup(input logic [TW-1:0] t);
        if (t == NONE)
            return '0;
        if (bus.cdb_valid && bus.cdb_tag == t)
            return {1'b1, bus.cdb_value};
        return {r_busy[t] & r_ready[t], r_value[t]};
    endfunction

    assign w_full       = (r_count == TW'(DEPTH));
    assign w_disp       = bus.dec_valid && !w_full;
    assign w_wb         = bus.cdb_valid && r_busy[bus.cdb_tag];
    assign w_commit     = r_busy[r_head] && r_ready[r_head];
    assign w_mispredict = (r_type[r_head] == ROB_TYPE_BRANCH) && (r_pred[r_head] != r_act[r_head]);

    assign bus.alloc_tag = r_tail;
    assign bus.full_out  = w_full;
    assign {bus.qry1_ready, bus.qry1_value} = lookup(bus.qry1_tag);
    assign {bus.qry2_ready, bus.qry2_value} = lookup(bus.qry2_tag);

    assign bus.commit_valid       = r_commit_valid;
    assign bus.commit_rd          = r_commit_rd;
    assign bus.commit_value       = r_commit_value;
    assign bus.commit_tag         = r_commit_tag;
    assign bus.store_commit_valid = r_store_commit_valid;
    assign bus.store_commit_tag   = r_store_commit_tag;
    assign bus.need_flush_out     = r_need_flush;
    assign bus.flush_pc           = r_flush_pc;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_pred  <= '0;
            r_act   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_type[i]  <= ROB_TYPE_REG;
                r_rd[i]    <= '0;
                r_value[i] <= '0;
                r_alt[i]   <= '0;
            end
            r_head               <= '0;
            r_tail               <= '0;
            r_count              <= '0;
            r_commit_valid       <= 1'b0;
            r_store_commit_valid <= 1'b0;
            r_need_flush         <= 1'b0;
            r_commit_rd          <= '0;
            r_commit_value       <= '0;
            r_commit_tag         <= '0;
            r_store_commit_tag   <= '0;
            r_flush_pc           <= '0;
        end else if (!rdy_in) begin
            r_commit_valid       <= 1'b0;
            r_store_commit_valid <= 1'b0;
            r_need_flush         <= 1'b0;
        end else begin
            r_commit_valid       <= 1'b0;
            r_store_commit_valid <= 1'b0;
            r_need_flush         <= 1'b0;
            if (r_need_flush) begin
                r_busy  <= '0;
                r_ready <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_wb) begin
                    r_ready[bus.cdb_tag] <= 1'b1;
                    r_value[bus.cdb_tag] <= bus.cdb_value;
                    r_act[bus.cdb_tag]   <= bus.cdb_taken;
                end
                // Retirement uses readiness from before this edge: no writeback-to-commit bypass.
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= inc(r_head);
                    case (r_type[r_head])
                        ROB_TYPE_REG: begin
                            r_commit_valid <= 1'b1;
                            r_commit_rd    <= r_rd[r_head];
                            r_commit_value <= r_value[r_head];
                            r_commit_tag   <= r_head;
                        end
                        ROB_TYPE_STORE: begin
                            r_store_commit_valid <= 1'b1;
                            r_store_commit_tag   <= r_head;
                        end
                        default: begin
                            if (w_mispredict) begin
                                r_need_flush <= 1'b1;
                                r_flush_pc   <= r_alt[r_head];
                            end
                        end
                    endcase
                end
                if (w_disp) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_type[r_tail]  <= bus.dec_type;
                    r_rd[r_tail]    <= bus.dec_rd;
                    r_pred[r_tail]  <= bus.dec_pred_taken;
                    r_alt[r_tail]   <= bus.dec_alt_pc;
                    r_tail          <= inc(r_tail);
                end
                r_count <= r_count + TW'(w_disp) - TW'(w_commit);
            end
        end
    end
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: commit latency, full/wrap, out-of-order writeback, mispredict flush,
// store release, CDB-forwarded queries, freeze and async reset.
module tb_rob;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    rob_if bus ();

    rob dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic dispatch(input rob_type_e t, input logic [4:0] rd, input logic pred,
                            input logic [31:0] alt);
        bus.dec_valid      = 1'b1;
        bus.dec_type       = t;
        bus.dec_rd         = rd;
        bus.dec_pred_taken = pred;
        bus.dec_alt_pc     = alt;
        tick();
        bus.dec_valid = 1'b0;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [31:0] val, input logic taken);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_value = val;
        bus.cdb_taken = taken;
        tick();
        bus.cdb_valid = 1'b0;
    endtask

    initial begin
        bus.dec_valid = 1'b0; bus.dec_type = ROB_TYPE_REG; bus.dec_rd = '0;
        bus.dec_pred_taken = 1'b0; bus.dec_alt_pc = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0; bus.cdb_taken = 1'b0;
        bus.qry1_tag = 3'd7; bus.qry2_tag = 3'd7;
        tick();
        chk("rst_commit_valid", 32'(bus.commit_valid), 0);
        chk("rst_store_valid",  32'(bus.store_commit_valid), 0);
        chk("rst_flush",        32'(bus.need_flush_out), 0);
        chk("rst_flush_pc",     bus.flush_pc, 0);
        chk("rst_commit_value", bus.commit_value, 0);
        rst = 1'b0;
        chk("rst_alloc_tag",    32'(bus.alloc_tag), 0);
        chk("rst_full",         32'(bus.full_out), 0);

        // Basic REG commit latency, then async reset kills the pulse.
        dispatch(ROB_TYPE_REG, 5'd5, 1'b0, 32'h0);
        chk("t1_alloc_after", 32'(bus.alloc_tag), 1);
        cdb(3'd0, 32'h1234, 1'b0);
        chk("t1_no_bypass", 32'(bus.commit_valid), 0);
        tick();
        chk("t1_commit_valid", 32'(bus.commit_valid), 1);
        chk("t1_commit_rd",    32'(bus.commit_rd), 5);
        chk("t1_commit_value", bus.commit_value, 32'h1234);
        chk("t1_commit_tag",   32'(bus.commit_tag), 0);
        rst = 1'b1;
        #1;
        chk("t1_rst_drops_pulse", 32'(bus.commit_valid), 0);
        chk("t1_rst_alloc",       32'(bus.alloc_tag), 0);
        rst = 1'b0;

        // Fill, refuse when full, then wrap.
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("t2_alloc_seq", 32'(bus.alloc_tag), 32'(i));
            dispatch(ROB_TYPE_REG, 5'(i + 1), 1'b0, 32'h0);
        end
        chk("t2_full", 32'(bus.full_out), 1);
        dispatch(ROB_TYPE_REG, 5'd31, 1'b0, 32'h0);
        chk("t2_full_hold", 32'(bus.full_out), 1);
        chk("t2_tail_hold", 32'(bus.alloc_tag), 0);
        cdb(3'd0, 32'hA, 1'b0);
        chk("t2_no_commit_yet", 32'(bus.commit_valid), 0);
        tick();
        chk("t2_commit_valid", 32'(bus.commit_valid), 1);
        chk("t2_commit_rd",    32'(bus.commit_rd), 1);
        chk("t2_not_full",     32'(bus.full_out), 0);
        chk("t2_wrap_tag",     32'(bus.alloc_tag), 0);
        dispatch(ROB_TYPE_REG, 5'd9, 1'b0, 32'h0);
        chk("t2_after_wrap",   32'(bus.alloc_tag), 1);
        chk("t2_full_again",   32'(bus.full_out), 1);

        // Out-of-order writeback: tag1 ready first.
        do_reset();
        tick();
        dispatch(ROB_TYPE_REG, 5'd3, 1'b0, 32'h0);
        dispatch(ROB_TYPE_REG, 5'd4, 1'b0, 32'h0);
        cdb(3'd1, 32'h11, 1'b0);
        tick();
        chk("t3_wait_a", 32'(bus.commit_valid), 0);
        tick();
        chk("t3_wait_b", 32'(bus.commit_valid), 0);
        cdb(3'd0, 32'h10, 1'b0);
        chk("t3_wait_c", 32'(bus.commit_valid), 0);
        tick();
        chk("t3_c0_valid", 32'(bus.commit_valid), 1);
        chk("t3_c0_tag",   32'(bus.commit_tag), 0);
        chk("t3_c0_value", bus.commit_value, 32'h10);
        tick();
        chk("t3_c1_valid", 32'(bus.commit_valid), 1);
        chk("t3_c1_tag",   32'(bus.commit_tag), 1);
        chk("t3_c1_rd",    32'(bus.commit_rd), 4);
        chk("t3_c1_value", bus.commit_value, 32'h11);
        tick();
        chk("t3_pulse_end", 32'(bus.commit_valid), 0);

        // Mispredicted branch flushes younger entries.
        do_reset();
        tick();
        dispatch(ROB_TYPE_BRANCH, 5'd0, 1'b1, 32'h100);
        dispatch(ROB_TYPE_REG, 5'd6, 1'b0, 32'h0);
        dispatch(ROB_TYPE_REG, 5'd7, 1'b0, 32'h0);
        cdb(3'd1, 32'h1, 1'b0);
        cdb(3'd2, 32'h2, 1'b0);
        cdb(3'd0, 32'h0, 1'b0);
        chk("t4_before_flush", 32'(bus.need_flush_out), 0);
        tick();
        chk("t4_flush",        32'(bus.need_flush_out), 1);
        chk("t4_flush_pc",     bus.flush_pc, 32'h100);
        chk("t4_no_commit_m",  32'(bus.commit_valid), 0);
        dispatch(ROB_TYPE_REG, 5'd8, 1'b0, 32'h0);
        chk("t4_flush_end",    32'(bus.need_flush_out), 0);
        chk("t4_no_commit_m1", 32'(bus.commit_valid), 0);
        chk("t4_empty_tag",    32'(bus.alloc_tag), 0);
        chk("t4_empty_full",   32'(bus.full_out), 0);
        tick();
        chk("t4_no_commit_m2", 32'(bus.commit_valid), 0);
        dispatch(ROB_TYPE_REG, 5'd9, 1'b0, 32'h0);
        chk("t4_new_tag", 32'(bus.alloc_tag), 1);
        cdb(3'd0, 32'h99, 1'b0);
        tick();
        chk("t4_new_commit", 32'(bus.commit_valid), 1);
        chk("t4_new_rd",     32'(bus.commit_rd), 9);

        // Store release on tag 2.
        do_reset();
        tick();
        dispatch(ROB_TYPE_REG, 5'd1, 1'b0, 32'h0);
        dispatch(ROB_TYPE_REG, 5'd2, 1'b0, 32'h0);
        dispatch(ROB_TYPE_STORE, 5'd0, 1'b0, 32'h0);
        cdb(3'd0, 32'h20, 1'b0);
        cdb(3'd1, 32'h21, 1'b0);
        cdb(3'd2, 32'h22, 1'b0);
        chk("t5_reg1_commit", 32'(bus.commit_tag), 1);
        tick();
        chk("t5_store_valid", 32'(bus.store_commit_valid), 1);
        chk("t5_store_tag",   32'(bus.store_commit_tag), 2);
        chk("t5_no_reg",      32'(bus.commit_valid), 0);
        tick();
        chk("t5_store_end",   32'(bus.store_commit_valid), 0);

        // Queries with CDB forwarding and the reserved tag.
        dispatch(ROB_TYPE_REG, 5'd3, 1'b0, 32'h0);
        bus.qry1_tag = 3'd3;
        bus.qry2_tag = 3'd3;
        #1;
        chk("t6_not_ready", 32'(bus.qry1_ready), 0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd3; bus.cdb_value = 32'h5555;
        #1;
        chk("t6_fwd_ready", 32'(bus.qry1_ready), 1);
        chk("t6_fwd_value", bus.qry1_value, 32'h5555);
        tick();
        bus.cdb_valid = 1'b0;
        #1;
        chk("t6_stored_ready", 32'(bus.qry2_ready), 1);
        chk("t6_stored_value", bus.qry2_value, 32'h5555);
        bus.qry1_tag = 3'd7;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd7; bus.cdb_value = 32'hBEEF;
        #1;
        chk("t6_none_ready", 32'(bus.qry1_ready), 0);
        chk("t6_none_value", bus.qry1_value, 0);
        bus.cdb_valid = 1'b0;

        // Freeze while rdy_in is low.
        tick();
        rdy = 1'b0;
        dispatch(ROB_TYPE_REG, 5'd4, 1'b0, 32'h0);
        chk("t7_frozen_tail", 32'(bus.alloc_tag), 4);
        rdy = 1'b1;
        dispatch(ROB_TYPE_REG, 5'd4, 1'b0, 32'h0);
        chk("t7_resumed_tail", 32'(bus.alloc_tag), 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
